// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit: default geometry, the per-cycle
// PC action encoding and the lane link-address helper.
package fetch_pc_unit_pkg;

    localparam int DEF_AW       = 32;
    localparam int DEF_ISSUE_W  = 2;
    localparam int DEF_RESET_PC = 0;
    localparam int NUM_STAGES   = 3;   // IM_ID, ID_EX, EX_DM

    typedef enum logic [1:0] {
        PC_ADVANCE  = 2'd0,
        PC_HOLD     = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_action_e;

    // Link (return) address of a lane in a fetch group: the instruction after it.
    function automatic logic [63:0] lane_link(input logic [63:0] base, input int unsigned lane);
        return base + 64'(lane) + 64'd1;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Control/observation bundle between the fetch PC unit (slave) and the core
// pipeline control that drives it (master).
interface fetch_pc_unit_if #(
    parameter int AW      = fetch_pc_unit_pkg::DEF_AW,
    parameter int ISSUE_W = fetch_pc_unit_pkg::DEF_ISSUE_W,
    parameter int CNT_W   = $clog2(ISSUE_W + 1)
);
    logic             hold;
    logic [CNT_W-1:0] adv_cnt;
    logic             redirect;
    logic [AW-1:0]    redirect_pc;
    logic [AW-1:0]    pc;
    logic [AW-1:0]    pc_IM_ID;
    logic             vld_IM_ID;
    logic [AW-1:0]    pc_ID_EX;
    logic             vld_ID_EX;
    logic [AW-1:0]    pc_EX_DM;
    logic             vld_EX_DM;
    logic             pend_redirect;

    modport master (
        output hold, adv_cnt, redirect, redirect_pc,
        input  pc, pc_IM_ID, vld_IM_ID, pc_ID_EX, vld_ID_EX,
               pc_EX_DM, vld_EX_DM, pend_redirect
    );

    modport slave (
        input  hold, adv_cnt, redirect, redirect_pc,
        output pc, pc_IM_ID, vld_IM_ID, pc_ID_EX, vld_ID_EX,
               pc_EX_DM, vld_EX_DM, pend_redirect
    );
endinterface

// File: rtl/fetch_pc_unit_stage_reg.sv
// One link-PC pipeline stage: pc+valid register that freezes on hold and
// drops its valid bit on flush.
module pc_stage_reg #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold_i,
    input  logic          flush_i,
    input  logic          load_i,
    input  logic [AW-1:0] pc_i,
    input  logic          vld_i,
    output logic [AW-1:0] pc_o,
    output logic          vld_o
);
    logic [AW-1:0] pc_q;
    logic          vld_q;

    // The pc field is only rewritten on load so a bubble keeps the last link address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            vld_q <= 1'b0;
        end else if (!hold_i) begin
            vld_q <= vld_i & ~flush_i;
            if (load_i) begin
                pc_q <= pc_i;
            end
        end
    end

    assign pc_o  = pc_q;
    assign vld_o = vld_q;
endmodule

// File: rtl/fetch_pc_unit.sv
// N-wide fetch program counter with held-redirect latching and a 3-stage
// link-PC pipeline. Optional perf counters when PC_PERF_EN is defined.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int            AW       = DEF_AW,
    parameter int            ISSUE_W  = DEF_ISSUE_W,
    parameter int            CNT_W    = $clog2(ISSUE_W + 1),
    parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef PC_PERF_EN
    output logic [31:0]          redir_cnt,
    output logic [31:0]          hold_cnt,
`endif
    fetch_pc_unit_if.slave       bus
);
    logic [AW-1:0]    pc_q, pc_d;
    logic [AW-1:0]    pend_pc_q, pend_pc_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] adv_sat;
    pc_action_e       action;

    assign adv_sat = (bus.adv_cnt > CNT_W'(ISSUE_W)) ? CNT_W'(ISSUE_W) : bus.adv_cnt;

    always_comb begin
        action = PC_ADVANCE;
        if (bus.hold) begin
            action = PC_HOLD;
        end else if (bus.redirect || pend_q) begin
            action = PC_REDIRECT;
        end
    end

    // A live redirect beats the latched one; under hold the oldest redirect is kept.
    always_comb begin
        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        unique case (action)
            PC_HOLD: begin
                if (bus.redirect && !pend_q) begin
                    pend_d    = 1'b1;
                    pend_pc_d = bus.redirect_pc;
                end
            end
            PC_REDIRECT: begin
                pc_d   = bus.redirect ? bus.redirect_pc : pend_pc_q;
                pend_d = 1'b0;
            end
            default: pc_d = pc_q + AW'(adv_sat);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    logic [AW-1:0] stg_d_pc  [NUM_STAGES];
    logic          stg_d_vld [NUM_STAGES];
    logic          stg_load  [NUM_STAGES];
    logic          stg_flush [NUM_STAGES];
    logic [AW-1:0] stg_q_pc  [NUM_STAGES];
    logic          stg_q_vld [NUM_STAGES];

    // Stage 0 captures the lane-0 link of the group being consumed; later stages shift.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_front
                assign stg_d_pc[gi]  = AW'(lane_link(64'(pc_q), 0));
                assign stg_d_vld[gi] = (adv_sat != '0);
                assign stg_load[gi]  = (action == PC_ADVANCE) && (adv_sat != '0);
                assign stg_flush[gi] = (action == PC_REDIRECT);
            end else begin : g_shift
                assign stg_d_pc[gi]  = stg_q_pc[gi-1];
                assign stg_d_vld[gi] = stg_q_vld[gi-1];
                assign stg_load[gi]  = 1'b1;
                assign stg_flush[gi] = (gi == 1) && (action == PC_REDIRECT);
            end

            pc_stage_reg #(.AW(AW)) u_stage (
                .clk    (clk),
                .rst    (rst),
                .hold_i (bus.hold),
                .flush_i(stg_flush[gi]),
                .load_i (stg_load[gi]),
                .pc_i   (stg_d_pc[gi]),
                .vld_i  (stg_d_vld[gi]),
                .pc_o   (stg_q_pc[gi]),
                .vld_o  (stg_q_vld[gi])
            );
        end
    endgenerate

    assign bus.pc            = pc_q;
    assign bus.pc_IM_ID      = stg_q_pc[0];
    assign bus.vld_IM_ID     = stg_q_vld[0];
    assign bus.pc_ID_EX      = stg_q_pc[1];
    assign bus.vld_ID_EX     = stg_q_vld[1];
    assign bus.pc_EX_DM      = stg_q_pc[2];
    assign bus.vld_EX_DM     = stg_q_vld[2];
    assign bus.pend_redirect = pend_q;

`ifdef PC_PERF_EN
    logic [31:0] redir_cnt_q, hold_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            redir_cnt_q <= '0;
            hold_cnt_q  <= '0;
        end else begin
            if (action == PC_REDIRECT && redir_cnt_q != '1) begin
                redir_cnt_q <= redir_cnt_q + 32'd1;
            end
            if (bus.hold && hold_cnt_q != '1) begin
                hold_cnt_q <= hold_cnt_q + 32'd1;
            end
        end
    end

    assign redir_cnt = redir_cnt_q;
    assign hold_cnt  = hold_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, reset-under-pend sequence,
// then random traffic against a queue-of-stages reference model.
module tb_fetch_pc_unit;
    localparam int AW      = 32;
    localparam int ISSUE_W = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_pc_unit_if #(.AW(AW), .ISSUE_W(ISSUE_W)) bus ();

`ifdef PC_PERF_EN
    logic [31:0] redir_cnt, hold_cnt;
`endif

    fetch_pc_unit #(.AW(AW), .ISSUE_W(ISSUE_W), .RESET_PC('0)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef PC_PERF_EN
        .redir_cnt(redir_cnt),
        .hold_cnt (hold_cnt),
`endif
        .bus      (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference state: fetch PC, pending redirect, and the link/valid of each stage.
    logic [31:0] m_pc, m_pend_pc;
    logic        m_pend;
    logic [31:0] m_spc [3];
    logic        m_svld[3];
    int unsigned m_redir, m_hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic h, input int adv,
                              input logic rd, input logic [31:0] rpc);
        logic take;
        int   n;
        if (r) begin
            m_pc = '0; m_pend = 0; m_pend_pc = '0;
            for (int i = 0; i < 3; i++) begin m_spc[i] = '0; m_svld[i] = 0; end
            m_redir = 0; m_hold = 0;
        end else if (h) begin
            m_hold++;
            if (rd && !m_pend) begin m_pend = 1; m_pend_pc = rpc; end
        end else begin
            take = rd || m_pend;
            m_spc[2] = m_spc[1]; m_svld[2] = m_svld[1];
            m_spc[1] = m_spc[0]; m_svld[1] = take ? 1'b0 : m_svld[0];
            if (take) begin
                m_redir++;
                m_svld[0] = 0;
                m_pc      = rd ? rpc : m_pend_pc;
                m_pend    = 0;
            end else begin
                n = (adv > ISSUE_W) ? ISSUE_W : adv;
                if (n == 0) m_svld[0] = 0;
                else begin m_spc[0] = m_pc + 32'd1; m_svld[0] = 1; end
                m_pc = m_pc + 32'(n);
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".pc"},   bus.pc, m_pc);
        check({tag, ".pend"}, 32'(bus.pend_redirect), 32'(m_pend));
        check({tag, ".vld_IM_ID"}, 32'(bus.vld_IM_ID), 32'(m_svld[0]));
        check({tag, ".vld_ID_EX"}, 32'(bus.vld_ID_EX), 32'(m_svld[1]));
        check({tag, ".vld_EX_DM"}, 32'(bus.vld_EX_DM), 32'(m_svld[2]));
        if (m_svld[0]) check({tag, ".pc_IM_ID"}, bus.pc_IM_ID, m_spc[0]);
        if (m_svld[1]) check({tag, ".pc_ID_EX"}, bus.pc_ID_EX, m_spc[1]);
        if (m_svld[2]) check({tag, ".pc_EX_DM"}, bus.pc_EX_DM, m_spc[2]);
    endtask

    // Apply one cycle of inputs (called at posedge+1), sample at the next posedge+1.
    task automatic cycle(input logic r, input logic h, input int adv,
                         input logic rd, input logic [31:0] rpc);
        rst = r; bus.hold = h; bus.adv_cnt = 2'(adv); bus.redirect = rd; bus.redirect_pc = rpc;
        @(posedge clk); #1;
        model_step(r, h, adv, rd, rpc);
        $display("[TB] rst=%0b hold=%0b adv=%0d redir=%0b rpc=0x%08h -> pc=0x%08h pend=%0b vld=%0b%0b%0b",
                 r, h, adv, rd, rpc, bus.pc, bus.pend_redirect,
                 bus.vld_IM_ID, bus.vld_ID_EX, bus.vld_EX_DM);
    endtask

    typedef struct {
        logic        hold;
        int          adv;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] exp_pc;
        logic        exp_vld_im;
        logic [31:0] exp_link;
        logic        exp_pend;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst = 1; bus.hold = 0; bus.adv_cnt = '0; bus.redirect = 0; bus.redirect_pc = '0;
        vecs.push_back('{1'b0, 2, 1'b0, 32'h0,        32'h2,        1'b1, 32'h1,   1'b0});
        vecs.push_back('{1'b0, 2, 1'b0, 32'h0,        32'h4,        1'b1, 32'h3,   1'b0});
        vecs.push_back('{1'b0, 1, 1'b0, 32'h0,        32'h5,        1'b1, 32'h5,   1'b0});
        vecs.push_back('{1'b0, 0, 1'b0, 32'h0,        32'h5,        1'b0, 32'h0,   1'b0});
        vecs.push_back('{1'b0, 2, 1'b0, 32'h0,        32'h7,        1'b1, 32'h6,   1'b0});
        vecs.push_back('{1'b0, 1, 1'b0, 32'h0,        32'h8,        1'b1, 32'h8,   1'b0});
        vecs.push_back('{1'b0, 2, 1'b1, 32'h100,      32'h100,      1'b0, 32'h0,   1'b0});
        vecs.push_back('{1'b0, 1, 1'b0, 32'h0,        32'h101,      1'b1, 32'h101, 1'b0});
        vecs.push_back('{1'b1, 2, 1'b1, 32'h40,       32'h101,      1'b1, 32'h101, 1'b1});
        vecs.push_back('{1'b1, 2, 1'b0, 32'h0,        32'h101,      1'b1, 32'h101, 1'b1});
        vecs.push_back('{1'b1, 1, 1'b0, 32'h0,        32'h101,      1'b1, 32'h101, 1'b1});
        vecs.push_back('{1'b0, 2, 1'b0, 32'h0,        32'h40,       1'b0, 32'h0,   1'b0});
        vecs.push_back('{1'b1, 1, 1'b1, 32'h40,       32'h40,       1'b0, 32'h0,   1'b1});
        vecs.push_back('{1'b1, 1, 1'b1, 32'h80,       32'h40,       1'b0, 32'h0,   1'b1});
        vecs.push_back('{1'b0, 1, 1'b0, 32'h0,        32'h40,       1'b0, 32'h0,   1'b0});
        vecs.push_back('{1'b0, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0,  1'b0});
        vecs.push_back('{1'b0, 2, 1'b0, 32'h0,        32'h1,        1'b1, 32'h0,   1'b0});
        vecs.push_back('{1'b0, 3, 1'b0, 32'h0,        32'h3,        1'b1, 32'h2,   1'b0});

        // Reset state
        @(posedge clk); #1;
        cycle(1, 0, 0, 0, 32'h0);
        check("reset.pc",   bus.pc, 32'h0);
        check("reset.vld",  32'({bus.vld_IM_ID, bus.vld_ID_EX, bus.vld_EX_DM}), 32'h0);
        check("reset.pend", 32'(bus.pend_redirect), 32'h0);
        compare_model("reset");

        foreach (vecs[i]) begin
            cycle(0, vecs[i].hold, vecs[i].adv, vecs[i].redir, vecs[i].rpc);
            check($sformatf("vec%0d.pc", i), bus.pc, vecs[i].exp_pc);
            check($sformatf("vec%0d.vld_IM_ID", i), 32'(bus.vld_IM_ID), 32'(vecs[i].exp_vld_im));
            check($sformatf("vec%0d.pend", i), 32'(bus.pend_redirect), 32'(vecs[i].exp_pend));
            if (vecs[i].exp_vld_im)
                check($sformatf("vec%0d.pc_IM_ID", i), bus.pc_IM_ID, vecs[i].exp_link);
            compare_model($sformatf("vec%0d", i));
        end

        // Reset while a redirect is pending under hold: reset wins, pend dropped.
        cycle(0, 0, 2, 0, 32'h0);
        cycle(0, 1, 2, 1, 32'h200);
        check("rstpend.pend_set", 32'(bus.pend_redirect), 32'h1);
        cycle(1, 1, 2, 0, 32'h0);
        check("rstpend.pc", bus.pc, 32'h0);
        check("rstpend.pend", 32'(bus.pend_redirect), 32'h0);
        cycle(0, 0, 1, 0, 32'h0);
        check("rstpend.after", bus.pc, 32'h1);
        compare_model("rstpend");

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic r, h, rd;
            int   adv;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) < 2);
            h   = ($urandom_range(0, 99) < 25);
            rd  = ($urandom_range(0, 99) < 15);
            adv = $urandom_range(0, 3);
            rpc = (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : $urandom());
            cycle(r, h, adv, rd, rpc);
            compare_model($sformatf("rnd%0d", k));
        end

`ifdef PC_PERF_EN
        check("perf.redir_cnt", redir_cnt, 32'(m_redir));
        check("perf.hold_cnt",  hold_cnt,  32'(m_hold));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
